// File: rtl/jt49_div.sv
// jt49_div: clock-enabled programmable divider producing a 50% square wave and a toggle tick.
// Define JT49_DIV_CHECK_EN to compile in simulation-only consistency checkers.
module jt49_div #(
    parameter int width = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic [width-1:0] period,
    output logic             div,
    output logic             tick
);
    logic [width-1:0] count;
    logic             hit;

    // count never drops below 1, so comparing against a raw 0 behaves as period 1
    assign hit = count >= period;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= width'(1);
            div   <= 1'b0;
            tick  <= 1'b0;
        end else begin
            tick <= cen & hit;
            if (cen) begin
                count <= hit ? width'(1) : count + width'(1);
                div   <= div ^ hit;
            end
        end
    end

`ifdef JT49_DIV_CHECK_EN
    logic             div_q;
    logic             cen_q;
    logic [width-1:0] lim_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= 1'b0;
            cen_q <= 1'b0;
            lim_q <= width'(1);
        end else begin
            div_q <= div;
            cen_q <= cen;
            if (cen) lim_q <= (period == '0) ? width'(1) : period;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (div != div_q && !cen_q) $error("jt49_div: div changed without cen");
            if (count == '0) $error("jt49_div: count is zero");
            if (count > lim_q) $error("jt49_div: count exceeds limit");
            if (tick != (div ^ div_q)) $error("jt49_div: tick does not match div toggle");
        end
    end
`endif
endmodule

// File: tb/tb_jt49_div.sv
// tb_jt49_div: directed checks of jt49_div (width 4) against hand-derived expectations.
module tb_jt49_div;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b1;
    logic [3:0] period = 4'd4;
    logic       div;
    logic       tick;
    int         n_run = 0;
    int         n_fail = 0;

    jt49_div #(.width(4)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .period(period), .div(div), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_run++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic restart(input logic [3:0] p);
        rst_n  = 1'b0;
        cen    = 1'b1;
        period = p;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int prev, last, en, pc;
        logic frozen;
        // reset held 50 ns with cen high
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_div", div, 0);
            check("rst_tick", tick, 0);
        end
        rst_n = 1'b1;
        // period 4: first rise on 4th edge, then every 4 edges
        repeat (3) @(negedge clk);
        check("p4_pre_div", div, 0);
        check("p4_pre_tick", tick, 0);
        @(negedge clk);
        check("p4_rise_div", div, 1);
        check("p4_rise_tick", tick, 1);
        @(negedge clk);
        check("p4_tick_once", tick, 0);
        repeat (3) @(negedge clk);
        check("p4_fall_div", div, 0);
        check("p4_fall_tick", tick, 1);
        repeat (5) @(negedge clk);
        check("p4_rise2_div", div, 1);
        // asynchronous reset mid-count
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_div", div, 0);
        check("mid_rst_tick", tick, 0);
        check("mid_rst_count", dut.count, 1);
        @(negedge clk);
        // period 0 and 1 toggle on every enabled edge
        for (int p = 0; p < 2; p++) begin
            restart(4'(p));
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                check($sformatf("p%0d_div%0d", p, k), div, k % 2);
                check($sformatf("p%0d_tick%0d", p, k), tick, 1);
            end
        end
        // sweep 0..15, 60 cycles per step; measure the last full half-period
        restart(4'd0);
        for (int p = 0; p < 16; p++) begin
            period = 4'(p);
            prev = -1;
            last = -1;
            for (int e = 0; e < 60; e++) begin
                @(negedge clk);
                if (tick) begin
                    prev = last;
                    last = e;
                end
            end
            check($sformatf("sweep_half_%0d", p), last - prev, (p == 0) ? 1 : p);
        end
        // raising 7 -> 8 mid-count continues without restart
        restart(4'd7);
        repeat (7) @(negedge clk);
        check("p7_first_div", div, 1);
        repeat (5) @(negedge clk);
        check("p7_count6", dut.count, 6);
        period = 4'd8;
        repeat (2) @(negedge clk);
        check("p78_no_tick", tick, 0);
        @(negedge clk);
        check("p78_tick", tick, 1);
        check("p78_div", div, 0);
        // lowering 12 -> 3 at count 9 toggles on the next edge
        restart(4'd12);
        repeat (8) @(negedge clk);
        check("p12_count9", dut.count, 9);
        check("p12_div", div, 0);
        period = 4'd3;
        @(negedge clk);
        check("drop_div", div, 1);
        check("drop_tick", tick, 1);
        repeat (2) @(negedge clk);
        check("drop_hold_tick", tick, 0);
        @(negedge clk);
        check("drop_div2", div, 0);
        check("drop_tick2", tick, 1);
        // cen every other cycle with period 4: toggle every 8 clk cycles
        restart(4'd4);
        en = 0;
        for (int c = 0; c < 24; c++) begin
            cen = (c % 2 == 0);
            pc = dut.count;
            frozen = div;
            @(negedge clk);
            if (cen) begin
                en++;
                check($sformatf("cen_div%0d", c), div, (en / 4) % 2);
                check($sformatf("cen_tick%0d", c), tick, (en % 4 == 0) ? 1 : 0);
            end else begin
                check($sformatf("cen_hold_div%0d", c), div, int'(frozen));
                check($sformatf("cen_hold_cnt%0d", c), dut.count, pc);
                check($sformatf("cen_tick_low%0d", c), tick, 0);
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
